// File: rtl/xmas_pkg.sv
// Shared types for the xmas merge/pipeline stages.
//   DATA_W_DEF   default payload width
//   xmas_src_e   source tag carried alongside each buffered word
//   xmas_entry_t {src, data} entry at the default payload width
package xmas_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } xmas_src_e;

   typedef struct packed {
      xmas_src_e               src;
      logic [DATA_W_DEF-1:0]   data;
   } xmas_entry_t;

endpackage

// File: rtl/xmas_fifo2.sv
// Generic 2-entry FIFO with synchronous active-low reset.
//   clk, rst_n  clock / synchronous active-low reset
//   push, din   write request and entry (ignored when full)
//   pop         read request (ignored when empty)
//   full, empty occupancy flags derived from the fill count
//   head        entry at the read pointer (meaningful only when ~empty)
module xmas_fifo2 #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   fill;
   logic         do_push;
   logic         do_pop;

   // Full/empty come from the fill count, so 1-bit pointers may wrap freely.
   assign full    = (fill == 2'd2);
   assign empty   = (fill == 2'd0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         fill   <= 2'd0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   fill <= fill + 2'd1;
            2'b01:   fill <= fill - 2'd1;
            default: fill <= fill;
         endcase
      end
   end

endmodule

// File: rtl/xmas_rr_merge.sv
// Two-channel round-robin merge ahead of the irdy/trdy pipeline.
// Accepts at most one of A/B per cycle, buffers winners in a 2-entry FIFO,
// tags each word with its source and counts accepted words per source.
//   clk, rst_n               clock / synchronous active-low reset
//   a_data, a_irdy, a_trdy   producer A channel
//   b_data, b_irdy, b_trdy   producer B channel
//   o_data, o_src, o_irdy    FIFO head toward the pipeline
//   o_trdy                   pipeline accepts the head
//   a_count, b_count         accepted-word counters, wrap silently
module xmas_rr_merge
   import xmas_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] a_data,
   input  logic              a_irdy,
   output logic              a_trdy,
   input  logic [DATA_W-1:0] b_data,
   input  logic              b_irdy,
   output logic              b_trdy,
   output logic [DATA_W-1:0] o_data,
   output logic              o_src,
   output logic              o_irdy,
   input  logic              o_trdy,
   output logic [CNT_W-1:0]  a_count,
   output logic [CNT_W-1:0]  b_count
);

   xmas_src_e     prio;
   logic          fifo_full;
   logic          fifo_empty;
   logic [DATA_W:0] fifo_head;
   logic [DATA_W:0] fifo_din;
   logic          push;
   logic          pop;
   logic          src_in;

   // trdy depends only on local state and irdy, never on o_trdy: a slot freed
   // by a pop this cycle is not reused until the next cycle.
   always_comb begin
      a_trdy = rst_n & ~fifo_full & a_irdy & ((prio == SRC_A) | ~b_irdy);
      b_trdy = rst_n & ~fifo_full & b_irdy & ((prio == SRC_B) | ~a_irdy);
   end

   assign push     = a_trdy | b_trdy;
   assign src_in   = b_trdy ? 1'(SRC_B) : 1'(SRC_A);
   assign fifo_din = {src_in, (b_trdy ? b_data : a_data)};

   assign o_irdy = rst_n & ~fifo_empty;
   assign pop    = o_irdy & o_trdy;
   assign o_data = o_irdy ? fifo_head[DATA_W-1:0] : '0;
   assign o_src  = o_irdy ? fifo_head[DATA_W] : 1'b0;

   xmas_fifo2 #(
      .W (DATA_W + 1)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio    <= SRC_A;
         a_count <= '0;
         b_count <= '0;
      end else begin
         if (a_trdy) begin
            prio    <= SRC_B;
            a_count <= a_count + CNT_W'(1);
         end else if (b_trdy) begin
            prio    <= SRC_A;
            b_count <= b_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_xmas_rr_merge.sv
module tb_xmas_rr_merge;

   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] a_data = '0;
   logic          a_irdy = 1'b0;
   logic          a_trdy;
   logic [DW-1:0] b_data = '0;
   logic          b_irdy = 1'b0;
   logic          b_trdy;
   logic [DW-1:0] o_data;
   logic          o_src;
   logic          o_irdy;
   logic          o_trdy = 1'b0;
   logic [CW-1:0] a_count;
   logic [CW-1:0] b_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   xmas_rr_merge #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_data  (a_data),
      .a_irdy  (a_irdy),
      .a_trdy  (a_trdy),
      .b_data  (b_data),
      .b_irdy  (b_irdy),
      .b_trdy  (b_trdy),
      .o_data  (o_data),
      .o_src   (o_src),
      .o_irdy  (o_irdy),
      .o_trdy  (o_trdy),
      .a_count (a_count),
      .b_count (b_count)
   );

   // Reference model: a queue of {src,data}, a "B has priority" bit and counts.
   logic [DW:0] m_q[$];
   bit          m_prio_b = 1'b0;
   int          m_a_cnt = 0;
   int          m_b_cnt = 0;

   function automatic bit exp_a_trdy();
      return rst_n && (m_q.size() < 2) && a_irdy && (!m_prio_b || !b_irdy);
   endfunction

   function automatic bit exp_b_trdy();
      return rst_n && (m_q.size() < 2) && b_irdy && (m_prio_b || !a_irdy);
   endfunction

   function automatic bit exp_o_irdy();
      return rst_n && (m_q.size() > 0);
   endfunction

   function automatic logic [DW-1:0] exp_o_data();
      logic [DW:0] e;
      if (!exp_o_irdy()) return '0;
      e = m_q[0];
      return e[DW-1:0];
   endfunction

   function automatic logic exp_o_src();
      logic [DW:0] e;
      if (!exp_o_irdy()) return 1'b0;
      e = m_q[0];
      return e[DW];
   endfunction

   always @(posedge clk) begin : ref_model
      bit ga, gb;
      ga = exp_a_trdy();
      gb = exp_b_trdy();
      if (!rst_n) begin
         m_q.delete();
         m_prio_b = 1'b0;
         m_a_cnt  = 0;
         m_b_cnt  = 0;
      end else begin
         if (m_q.size() > 0 && o_trdy) void'(m_q.pop_front());
         if (ga) begin
            m_q.push_back({1'b0, a_data});
            m_prio_b = 1'b1;
            m_a_cnt  = (m_a_cnt + 1) % (1 << CW);
         end else if (gb) begin
            m_q.push_back({1'b1, b_data});
            m_prio_b = 1'b0;
            m_b_cnt  = (m_b_cnt + 1) % (1 << CW);
         end
      end
   end

   task automatic next();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n  = 1'b0;
      a_irdy = 1'b0;
      b_irdy = 1'b0;
      o_trdy = 1'b0;
      next();
      next();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      a_irdy = 1'b1;
      b_irdy = 1'b1;
      a_data = 32'hA5A5_0001;
      b_data = 32'hB5B5_0001;
      o_trdy = 1'b1;
      next();
      next();
      #1;
      n_cmp++; if (a_trdy !== 1'b0) begin n_bad++; $display("FAIL rst_a_trdy got=%b want=0", a_trdy); end
      n_cmp++; if (b_trdy !== 1'b0) begin n_bad++; $display("FAIL rst_b_trdy got=%b want=0", b_trdy); end
      n_cmp++; if (o_irdy !== 1'b0) begin n_bad++; $display("FAIL rst_o_irdy got=%b want=0", o_irdy); end
      n_cmp++; if (o_data !== '0) begin n_bad++; $display("FAIL rst_o_data got=%h want=0", o_data); end
      n_cmp++; if (a_count !== '0 || b_count !== '0) begin n_bad++; $display("FAIL rst_counts got=%0d/%0d want=0/0", a_count, b_count); end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (a_trdy !== 1'b1 || b_trdy !== 1'b0) begin n_bad++; $display("FAIL rst_first_grant got a=%b b=%b want a=1 b=0", a_trdy, b_trdy); end
      next();
      a_irdy = 1'b0;
      b_irdy = 1'b0;
      #1;
      n_cmp++; if (o_irdy !== 1'b1 || o_src !== 1'b0 || o_data !== 32'hA5A5_0001) begin
         n_bad++; $display("FAIL rst_first_word got irdy=%b src=%b data=%h want 1/0/a5a50001", o_irdy, o_src, o_data);
      end
      next();
   endtask

   task automatic test_alternation();
      logic [DW-1:0] vals [4];
      vals = '{32'h11, 32'h22, 32'h33, 32'h44};
      apply_reset();
      o_trdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a_irdy = 1'b1;
         b_irdy = 1'b1;
         a_data = vals[k];
         b_data = vals[k];
         next();
         #1;
         n_cmp++; if (o_irdy !== 1'b1 || o_src !== 1'(k % 2) || o_data !== vals[k]) begin
            n_bad++; $display("FAIL alt_word%0d got irdy=%b src=%b data=%h want 1/%0d/%h", k, o_irdy, o_src, o_data, k % 2, vals[k]);
         end
      end
      a_irdy = 1'b0;
      b_irdy = 1'b0;
      #1;
      n_cmp++; if (a_count !== 4'd2 || b_count !== 4'd2) begin n_bad++; $display("FAIL alt_counts got=%0d/%0d want=2/2", a_count, b_count); end
      next();
   endtask

   task automatic test_backpressure();
      apply_reset();
      o_trdy = 1'b0;
      a_irdy = 1'b1;
      a_data = 32'hDEAD_0001;
      next();
      a_data = 32'hDEAD_0002;
      next();
      a_data = 32'hDEAD_0003;
      #1;
      n_cmp++; if (a_trdy !== 1'b0) begin n_bad++; $display("FAIL bp_full_trdy got=%b want=0", a_trdy); end
      next();
      #1;
      n_cmp++; if (o_data !== 32'hDEAD_0001 || o_irdy !== 1'b1) begin n_bad++; $display("FAIL bp_head_hold got=%h want=dead0001", o_data); end
      o_trdy = 1'b1;
      #1;
      n_cmp++; if (a_trdy !== 1'b0) begin n_bad++; $display("FAIL bp_pop_cycle_trdy got=%b want=0", a_trdy); end
      next();
      o_trdy = 1'b0;
      #1;
      n_cmp++; if (o_data !== 32'hDEAD_0002) begin n_bad++; $display("FAIL bp_head_after_pop got=%h want=dead0002", o_data); end
      n_cmp++; if (a_trdy !== 1'b1) begin n_bad++; $display("FAIL bp_trdy_after_pop got=%b want=1", a_trdy); end
      a_irdy = 1'b0;
      next();
   endtask

   task automatic test_push_pop();
      apply_reset();
      o_trdy = 1'b0;
      a_irdy = 1'b1;
      a_data = 32'hC0DE_0001;
      next();
      a_data = 32'hC0DE_0002;
      o_trdy = 1'b1;
      #1;
      n_cmp++; if (a_trdy !== 1'b1) begin n_bad++; $display("FAIL pp_trdy got=%b want=1", a_trdy); end
      next();
      a_irdy = 1'b0;
      o_trdy = 1'b0;
      #1;
      n_cmp++; if (o_irdy !== 1'b1 || o_data !== 32'hC0DE_0002) begin n_bad++; $display("FAIL pp_head got irdy=%b data=%h want 1/c0de0002", o_irdy, o_data); end
      o_trdy = 1'b1;
      next();
      #1;
      n_cmp++; if (o_irdy !== 1'b0) begin n_bad++; $display("FAIL pp_single_entry got irdy=%b want=0", o_irdy); end
      o_trdy = 1'b0;
   endtask

   task automatic test_wrap();
      apply_reset();
      o_trdy = 1'b1;
      a_irdy = 1'b0;
      b_irdy = 1'b1;
      for (int i = 0; i < 17; i++) begin
         b_data = DW'(i);
         next();
      end
      b_irdy = 1'b0;
      #1;
      n_cmp++; if (b_count !== 4'd1 || a_count !== 4'd0) begin n_bad++; $display("FAIL wrap_counts got=%0d/%0d want=0/1", a_count, b_count); end
      next();
   endtask

   task automatic test_mid_reset();
      apply_reset();
      o_trdy = 1'b0;
      a_irdy = 1'b1;
      a_data = 32'hBAD0_0001;
      next();
      a_data = 32'hBAD0_0002;
      next();
      a_irdy = 1'b0;
      rst_n  = 1'b0;
      #1;
      n_cmp++; if (o_irdy !== 1'b0 || o_data !== '0) begin n_bad++; $display("FAIL mr_during got irdy=%b data=%h want 0/0", o_irdy, o_data); end
      next();
      rst_n = 1'b1;
      #1;
      n_cmp++; if (o_irdy !== 1'b0 || o_data !== '0) begin n_bad++; $display("FAIL mr_after got irdy=%b data=%h want 0/0", o_irdy, o_data); end
      o_trdy = 1'b1;
      a_irdy = 1'b1;
      a_data = 32'h600D_0001;
      next();
      a_irdy = 1'b0;
      #1;
      n_cmp++; if (o_irdy !== 1'b1 || o_data !== 32'h600D_0001) begin n_bad++; $display("FAIL mr_new_word got irdy=%b data=%h want 1/600d0001", o_irdy, o_data); end
      for (int i = 0; i < 3; i++) begin
         next();
         #1;
         n_cmp++; if (o_irdy !== 1'b0) begin n_bad++; $display("FAIL mr_stale%0d got irdy=%b data=%h want empty", i, o_irdy, o_data); end
      end
      o_trdy = 1'b0;
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         rst_n  = ($urandom_range(0, 49) != 0);
         a_irdy = ($urandom_range(0, 3) != 0);
         b_irdy = ($urandom_range(0, 3) != 0);
         a_data = $urandom;
         b_data = $urandom;
         o_trdy = ($urandom_range(0, 1) != 0);
         #1;
         n_cmp++; if (a_trdy !== exp_a_trdy()) begin n_bad++; $display("FAIL rnd_a_trdy c=%0d got=%b want=%b", c, a_trdy, exp_a_trdy()); end
         n_cmp++; if (b_trdy !== exp_b_trdy()) begin n_bad++; $display("FAIL rnd_b_trdy c=%0d got=%b want=%b", c, b_trdy, exp_b_trdy()); end
         n_cmp++; if (o_irdy !== exp_o_irdy()) begin n_bad++; $display("FAIL rnd_o_irdy c=%0d got=%b want=%b", c, o_irdy, exp_o_irdy()); end
         n_cmp++; if (o_data !== exp_o_data() || o_src !== exp_o_src()) begin
            n_bad++; $display("FAIL rnd_head c=%0d got=%b/%h want=%b/%h", c, o_src, o_data, exp_o_src(), exp_o_data());
         end
         n_cmp++; if (a_count !== CW'(m_a_cnt) || b_count !== CW'(m_b_cnt)) begin
            n_bad++; $display("FAIL rnd_counts c=%0d got=%0d/%0d want=%0d/%0d", c, a_count, b_count, m_a_cnt, m_b_cnt);
         end
         next();
      end
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_alternation();
      test_backpressure();
      test_push_pop();
      test_wrap();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
